window_extrema_tracker: RTL and testbench



---
 rtl/window_extrema_tracker.sv | 122 ++++++++++++
 tb/tb_window_extrema_tracker.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/window_extrema_tracker.sv
// Windowed running max/min/count over the comparator result stream.
// A completed window is held on a valid/ready port until accepted.
module window_extrema_tracker #(
    parameter  int WIDTH  = 8,
    parameter  int WINDOW = 8,
    localparam int CW     = $clog2(WINDOW + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    output logic [WIDTH-1:0] out_max,
    output logic [WIDTH-1:0] out_min,
    output logic [CW-1:0]    out_count,
    output logic             out_valid,
    input  logic             out_ready
);

    // state   | meaning
    // S_IDLE  | window empty
    // S_ACCUM | 1..WINDOW-1 samples held
    // S_HOLD  | result presented, waiting for handshake
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_max;
    logic [WIDTH-1:0] r_min;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_out_max;
    logic [WIDTH-1:0] r_out_min;
    logic [CW-1:0]    r_out_cnt;

    state_t           w_state_nxt;
    logic [WIDTH-1:0] w_max_nxt;
    logic [WIDTH-1:0] w_min_nxt;
    logic [CW-1:0]    w_cnt_nxt;
    logic             w_close;
    logic             w_accept;

    assign in_ready  = (r_state != S_HOLD);
    assign out_valid = (r_state == S_HOLD);
    assign w_accept  = in_valid & in_ready;
    assign out_max   = r_out_max;
    assign out_min   = r_out_min;
    assign out_count = r_out_cnt;

    always_comb begin
        w_state_nxt = r_state;
        w_max_nxt   = r_max;
        w_min_nxt   = r_min;
        w_cnt_nxt   = r_cnt;
        w_close     = 1'b0;
        case (r_state)
            S_IDLE: begin
                // A lone flush here is dropped so no empty window is ever emitted.
                if (w_accept) begin
                    w_max_nxt = in_data;
                    w_min_nxt = in_data;
                    w_cnt_nxt = CW'(1);
                    if (flush) begin
                        w_close     = 1'b1;
                        w_state_nxt = S_HOLD;
                    end else begin
                        w_state_nxt = S_ACCUM;
                    end
                end
            end
            S_ACCUM: begin
                if (w_accept) begin
                    w_max_nxt = (in_data > r_max) ? in_data : r_max;
                    w_min_nxt = (in_data < r_min) ? in_data : r_min;
                    w_cnt_nxt = r_cnt + CW'(1);
                    if ((w_cnt_nxt == CW'(WINDOW)) || flush) begin
                        w_close     = 1'b1;
                        w_state_nxt = S_HOLD;
                    end
                end else if (flush) begin
                    w_close     = 1'b1;
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_max     <= '0;
            r_min     <= '0;
            r_cnt     <= '0;
            r_out_max <= '0;
            r_out_min <= '0;
            r_out_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_max   <= w_max_nxt;
            r_min   <= w_min_nxt;
            r_cnt   <= w_cnt_nxt;
            // Result registers change only on entry to HOLD, so they stay put under backpressure.
            if (w_close) begin
                r_out_max <= w_max_nxt;
                r_out_min <= w_min_nxt;
                r_out_cnt <= w_cnt_nxt;
            end
        end
    end

endmodule

// File: tb/tb_window_extrema_tracker.sv
// Scoreboard bench: a queue-based window model predicts results; a negedge monitor
// pops and compares on every output handshake.
module tb_window_extrema_tracker;

    localparam int WIDTH  = 8;
    localparam int WINDOW = 4;
    localparam int CW     = $clog2(WINDOW + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             flush = 1'b0;
    logic [WIDTH-1:0] out_max;
    logic [WIDTH-1:0] out_min;
    logic [CW-1:0]    out_count;
    logic             out_valid;
    logic             out_ready = 1'b0;

    window_extrema_tracker #(.WIDTH(WIDTH), .WINDOW(WINDOW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_max   (out_max),
        .out_min   (out_min),
        .out_count (out_count),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        int mx;
        int mn;
        int cnt;
    } res_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    res_t exp_q[$];
    int   win_q[$];
    bit   m_busy = 1'b0;

    task automatic chk(input string nm, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, expv, $time);
        end
    endtask

    // Reference: a window is just the list of accepted samples; result is max/min/size of it.
    task automatic close_window();
        res_t r;
        r.mx  = win_q[0];
        r.mn  = win_q[0];
        r.cnt = win_q.size();
        foreach (win_q[i]) begin
            if (win_q[i] > r.mx) r.mx = win_q[i];
            if (win_q[i] < r.mn) r.mn = win_q[i];
        end
        exp_q.push_back(r);
        win_q.delete();
        m_busy = 1'b1;
    endtask

    task automatic cycle(input bit vv, input logic [7:0] dd, input bit ff, input bit oo);
        in_valid  = vv;
        in_data   = dd;
        flush     = ff;
        out_ready = oo;
        @(negedge clk);
        chk("in_ready", int'(in_ready), int'(!m_busy));
        chk("out_valid", int'(out_valid), int'(m_busy));
        @(posedge clk);
        if (m_busy) begin
            if (oo) m_busy = 1'b0;
        end else if (vv) begin
            win_q.push_back(int'(dd));
            if (win_q.size() == WINDOW || ff) close_window();
        end else if (ff && win_q.size() > 0) begin
            close_window();
        end
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        win_q.delete();
        exp_q.delete();
        m_busy = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_max", int'(out_max), 0);
        chk("rst_out_min", int'(out_min), 0);
        chk("rst_out_count", int'(out_count), 0);
        @(posedge clk);
        #1;
    endtask

    bit         prev_hold = 1'b0;
    logic [7:0] p_mx, p_mn;
    logic [CW-1:0] p_cnt;

    always @(negedge clk) begin
        if (rst) begin
            prev_hold = 1'b0;
        end else begin
            if (out_valid) begin
                chk("count_nonzero", int'(out_count != 0), 1);
                if (prev_hold) begin
                    chk("stable_max", int'(out_max), int'(p_mx));
                    chk("stable_min", int'(out_min), int'(p_mn));
                    chk("stable_count", int'(out_count), int'(p_cnt));
                end
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    res_t r;
                    r = exp_q.pop_front();
                    chk("out_max", int'(out_max), r.mx);
                    chk("out_min", int'(out_min), r.mn);
                    chk("out_count", int'(out_count), r.cnt);
                end
            end
            prev_hold = out_valid && !out_ready;
            p_mx  = out_max;
            p_mn  = out_min;
            p_cnt = out_count;
        end
    end

    initial begin
        logic [7:0] s6 [4];
        int k;
        do_reset();

        // 1: full window back-to-back
        cycle(1, 8'h10, 0, 1);
        cycle(1, 8'h80, 0, 1);
        cycle(1, 8'h05, 0, 1);
        cycle(1, 8'h80, 0, 1);
        cycle(0, 8'h00, 0, 1);
        cycle(0, 8'h00, 0, 1);

        // 2: backpressure for 5 cycles, in_valid held high meanwhile
        cycle(1, 8'h10, 0, 0);
        cycle(1, 8'h80, 0, 0);
        cycle(1, 8'h05, 0, 0);
        cycle(1, 8'h80, 0, 0);
        for (int i = 0; i < 5; i++) cycle(1, 8'hEE, 1, 0);
        cycle(0, 8'h00, 0, 1);
        cycle(0, 8'h00, 0, 1);

        // 3: early flush with data, then flush alone in IDLE
        cycle(1, 8'h33, 0, 1);
        cycle(1, 8'h22, 1, 1);
        cycle(0, 8'h00, 0, 1);
        cycle(0, 8'h00, 1, 1);
        cycle(0, 8'h00, 0, 1);
        cycle(0, 8'h00, 0, 1);

        // 4: flush without data in ACCUM
        cycle(1, 8'hFF, 0, 1);
        cycle(0, 8'h00, 1, 1);
        cycle(0, 8'h00, 0, 1);
        cycle(0, 8'h00, 0, 1);

        // 5: reset mid-window
        cycle(1, 8'h01, 0, 1);
        cycle(1, 8'h02, 0, 1);
        do_reset();
        cycle(1, 8'h40, 0, 1);
        cycle(1, 8'h41, 0, 1);
        cycle(1, 8'h42, 0, 1);
        cycle(1, 8'h43, 0, 1);
        cycle(0, 8'h00, 0, 1);
        cycle(0, 8'h00, 0, 1);

        // 6: gapped input; in_valid kept high during HOLD
        s6[0] = 8'h00; s6[1] = 8'hFF; s6[2] = 8'h7F; s6[3] = 8'h80;
        k = 0;
        while (k < 4) begin
            if ($urandom_range(0, 2) == 0) begin
                cycle(0, 8'($urandom), 0, 0);
            end else begin
                cycle(1, s6[k], 0, 0);
                k++;
            end
        end
        for (int i = 0; i < 3; i++) cycle(1, 8'hAA, 0, 0);
        cycle(1, 8'hAA, 0, 1);
        cycle(0, 8'h00, 0, 1);

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            cycle($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 9) == 0,
                  $urandom_range(0, 2) != 0);
        end
        for (int i = 0; i < 3; i++) cycle(0, 8'h00, 0, 1);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
